// File: rtl/serial_tx_piso.sv
// Parallel-in/serial-out frame transmitter: start bit, WIDTH data bits, stop bit,
// each bit held DIV clocks. Word accepted via valid/ready while idle.
module serial_tx_piso #(
  parameter int WIDTH     = 8,
  parameter int DIV       = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             tx_out,
  output logic             tx_active,
  output logic             done
);

  localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BIT_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [1:0]        state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [WIDTH-1:0]  sr;
  logic              baud_wrap;
  logic              next_bit;
  logic [WIDTH-1:0]  sr_shifted;

  // The outgoing bit is taken from the shift register and the register shifted
  // in the same edge, so tx_out stays registered for any WIDTH including 1.
  always_comb begin
    baud_wrap = (baud_cnt == BAUD_LAST);
    if (MSB_FIRST) begin
      next_bit   = sr[WIDTH-1];
      sr_shifted = sr << 1;
    end else begin
      next_bit   = sr[0];
      sr_shifted = sr >> 1;
    end
  end

  assign load_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      sr        <= '0;
      tx_out    <= 1'b1;
      tx_active <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done      <= 1'b0;
          tx_out    <= 1'b1;
          tx_active <= 1'b0;
          baud_cnt  <= '0;
          bit_cnt   <= '0;
          if (load_valid) begin
            sr        <= data_in;
            state     <= START;
            tx_out    <= 1'b0;
            tx_active <= 1'b1;
          end
        end
        START: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx_out   <= next_bit;
            sr       <= sr_shifted;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_wrap) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              state  <= STOP;
              tx_out <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx_out  <= next_bit;
              sr      <= sr_shifted;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_wrap) begin
            baud_cnt  <= '0;
            state     <= IDLE;
            tx_out    <= 1'b1;
            tx_active <= 1'b0;
            done      <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
